// File: rtl/pc_unit.sv
// pc_unit: program counter with increment, jump, call/return and a register-based return-address stack
module pc_unit #(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 8,
  localparam int AW = $clog2(STACK_DEPTH),
  localparam int DW = AW + 1
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_sync_reset,
  input  logic [WIDTH-1:0] i_in,
  input  logic             i_load,
  input  logic             i_inc,
  input  logic             i_call,
  input  logic             i_ret,
  output logic [WIDTH-1:0] o_out,
  output logic [DW-1:0]    o_depth,
  output logic             o_stack_full,
  output logic             o_stack_empty,
  output logic             o_overflow,
  output logic             o_underflow
);
  logic [WIDTH-1:0] r_pc;
  logic [DW-1:0]    r_depth;
  logic             r_ovf;
  logic             r_unf;
  logic [WIDTH-1:0] r_stack [STACK_DEPTH];
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_top;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [DW-1:0]    w_depth_nxt;
  logic             w_ovf_nxt;
  logic             w_unf_nxt;
  logic             w_push;
  logic             w_full;
  logic             w_empty;

  assign w_pc_inc = r_pc + WIDTH'(1);
  assign w_full   = r_depth == DW'(STACK_DEPTH);
  assign w_empty  = r_depth == '0;
  assign w_top    = r_stack[AW'(r_depth - DW'(1))];

  // Fixed-priority op select: sync_reset > ret > call > load > inc > hold
  always_comb begin
    w_pc_nxt    = r_pc;
    w_depth_nxt = r_depth;
    w_ovf_nxt   = r_ovf;
    w_unf_nxt   = r_unf;
    w_push      = 1'b0;
    if (i_sync_reset) begin
      w_pc_nxt    = '0;
      w_depth_nxt = '0;
      w_ovf_nxt   = 1'b0;
      w_unf_nxt   = 1'b0;
    end else if (i_ret) begin
      if (w_empty) w_unf_nxt = 1'b1;
      else begin
        w_pc_nxt    = w_top;
        w_depth_nxt = r_depth - DW'(1);
      end
    end else if (i_call) begin
      w_pc_nxt = i_in;
      if (w_full) w_ovf_nxt = 1'b1;
      else begin
        w_push      = 1'b1;
        w_depth_nxt = r_depth + DW'(1);
      end
    end else if (i_load) begin
      w_pc_nxt = i_in;
    end else if (i_inc) begin
      w_pc_nxt = w_pc_inc;
    end
  end

  // Architectural state: pc, stack depth and sticky error flags
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pc    <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_depth <= w_depth_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  // Return-address storage; slots at or above depth are never read, so no reset needed
  always_ff @(posedge i_clock) begin
    if (w_push) r_stack[AW'(r_depth)] <= w_pc_inc;
  end

  assign o_out         = r_pc;
  assign o_depth       = r_depth;
  assign o_stack_full  = w_full;
  assign o_stack_empty = w_empty;
  assign o_overflow    = r_ovf;
  assign o_underflow   = r_unf;
endmodule
